fifo_write_arbiter: RTL and testbench
=====================================

Name: fifo_write_arbiter

Overview:
- Shares the single write port of one fifo instance between two producers, e.g. the coax receive path and the host command path.
- Grants in bursts: one producer owns the port until its burst ends, then ownership passes round-robin to the other.
- Drives fifo wen/write directly and watches fifo occupancy for backpressure, so a word is never dropped at full.

Parameters:
- WIDTH, 8, data word width; must match the fifo WIDTH.
- DEPTH, 5, fifo address bits; the fifo holds at most 2**DEPTH-1 words.
- MAX_BURST, 8, maximum words per grant; legal range 1..255.
- HIGH_WATER, 24, no new burst starts while occupancy >= HIGH_WATER.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- req0  input  1  producer 0 has data0 valid.
- data0  input  WIDTH  producer 0 word.
- last0  input  1  data0 is the final word of producer 0's burst.
- ack0  output  1  data0 is accepted this cycle; producer advances next cycle.
- req1, data1, last1, ack1: the same four signals for producer 1.
- fifo_occupancy  input  DEPTH  connected to the fifo occupancy output.
- fifo_wen  output  1  connected to the fifo wen input; the fifo's mode input is tied 0.
- fifo_write  output  WIDTH  connected to the fifo write input.
- owner  output  1  current or most recent grant holder.
- busy  output  1  a grant is active (state OWN0 or OWN1).

Behaviour:
- States are IDLE, OWN0 and OWN1, plus a registered burst counter cnt (8 bits) and a last-served bit lsv.
- Reset values: state=IDLE, cnt=0, lsv=1 (producer 0 wins the first arbitration), owner=0, busy=0. ack0, ack1 and fifo_wen are 0 while reset is asserted.
- Full condition: full = (fifo_occupancy == 2**DEPTH-1).
- Start condition: can_start = (fifo_occupancy < HIGH_WATER).
- Acknowledge, combinational from registered state:
  - ackN = (state==OWNN) && reqN && !full.
  - fifo_wen = ack0 | ack1.
  - fifo_write = the owner's data, muxed by state; it is don't-care when fifo_wen=0.
- Request-to-first-ack latency is one cycle: a grant is registered in IDLE and the acks begin the next cycle.
- Arbitration function pick(), used in IDLE and at burst end:
  - If can_start is 0, go to IDLE.
  - If both producers request, grant the producer != lsv.
  - If exactly one requests, grant it.
  - If neither requests, go to IDLE.
  - On a grant: cnt<=0, owner<=granted producer, lsv<=granted producer.
- IDLE: state<=pick().
- OWNN: on each ackN, cnt<=cnt+1.
- Burst end in OWNN occurs when either:
  - ackN && (lastN || cnt==MAX_BURST-1), or
  - reqN==0, meaning the producer abandoned the burst; no word is written that cycle.
- At burst end, state<=pick() in the same cycle. Back-to-back handover has no IDLE bubble.
- Full during a burst: the grant is held, ack stays 0 and cnt is unchanged; the burst resumes when occupancy drops. HIGH_WATER does not interrupt a burst already in progress.
- The non-owner's ack is always 0. Its req and data may change freely.
- Producers must hold req/data/last stable until acked. A word is never written twice, and no word is written while full.
- Reset asserted mid-burst: acks and fifo_wen drop at once and state returns to IDLE. A word presented in that cycle is lost; the producer retransmits it.
- MAX_BURST=1: every acked word ends the burst, so arbitration alternates word by word when both producers request.

Optional Feature:
- Macro: FIFO_ARB_PRIO_EN.
- Defined: pick() ignores lsv and always grants producer 0 when req0=1. Round-robin is replaced by strict priority at each burst end; MAX_BURST and HIGH_WATER still apply.
- Undefined: round-robin as described above. lsv is still kept so that owner behaves identically in both builds.

Test Plan:
- Single burst: reset, fifo empty, req0 with 3 words, last0 on word 3 -> first ack0 in cycle 2, three consecutive fifo_wen, then IDLE with busy=0; occupancy reads 3.
- Round-robin: req0 and req1 held with MAX_BURST=4 and no last -> writes 4 from p0, then 4 from p1, then 4 from p0, with no idle cycle between bursts; owner toggles every 4 writes.
- Full stall: preload 30 words, DEPTH=5, p1 bursting with the fifo read disabled -> one write lands (occupancy 31), then ack1=0 and fifo_wen=0; one fifo read -> exactly one more write; 31 is never exceeded.
- High water: occupancy 24, req0 in IDLE -> no grant; drain to 23 -> grant the next cycle.
- Abandon and reset: p0 drops req0 after 2 of 5 words -> IDLE, and p1 is granted if requesting. Separately, assert reset mid-burst -> ack/wen are 0 in the same cycle, and the next arbitration after reset favours p0.
- FIFO_ARB_PRIO_EN defined, both producers requesting, MAX_BURST=2 -> p0 receives every burst while req0=1; p1 is granted only after req0 drops.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: shares one fifo write port between two producers.
// Ownership is granted per burst and handed round-robin at each burst end.
// Optional build macro FIFO_ARB_PRIO_EN: producer 0 gets strict priority at
// every arbitration point instead of round-robin.
module fifo_write_arbiter #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 5,
  parameter int unsigned MAX_BURST  = 8,
  parameter int unsigned HIGH_WATER = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             last0,
  output logic             ack0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  input  logic             last1,
  output logic             ack1,
  input  logic [DEPTH-1:0] fifo_occupancy,
  output logic             fifo_wen,
  output logic [WIDTH-1:0] fifo_write,
  output logic             owner,
  output logic             busy
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(MAX_BURST - 1);
  localparam logic [DEPTH-1:0] OCC_FULL = {DEPTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lsv_q, lsv_d;
  logic             owner_q, owner_d;
  logic             busy_q, busy_d;

  logic             full_c;
  logic             can_start_c;
  logic             pick_valid_c;
  logic             pick_id_c;
  logic             arb_c;

  // Occupancy thresholds: hard stop at full, no new burst at high water.
  assign full_c      = (fifo_occupancy == OCC_FULL);
  assign can_start_c = (32'(fifo_occupancy) < HIGH_WATER);

  // Acks come straight from the registered grant so a word lands the cycle it is offered.
  assign ack0       = (state_q == OWN0) && req0 && !full_c;
  assign ack1       = (state_q == OWN1) && req1 && !full_c;
  assign fifo_wen   = ack0 | ack1;
  assign fifo_write = (state_q == OWN1) ? data1 : data0;
  assign owner      = owner_q;
  assign busy       = busy_q;

  // Arbitration choice used in IDLE and at every burst end.
  always_comb begin
    pick_valid_c = 1'b0;
    pick_id_c    = 1'b0;
    if (can_start_c) begin
`ifdef FIFO_ARB_PRIO_EN
      if (req0) begin
        pick_valid_c = 1'b1;
        pick_id_c    = 1'b0;
      end else if (req1) begin
        pick_valid_c = 1'b1;
        pick_id_c    = 1'b1;
      end
`else
      if (req0 && req1) begin
        pick_valid_c = 1'b1;
        pick_id_c    = ~lsv_q;
      end else if (req0) begin
        pick_valid_c = 1'b1;
        pick_id_c    = 1'b0;
      end else if (req1) begin
        pick_valid_c = 1'b1;
        pick_id_c    = 1'b1;
      end
`endif
    end
  end

  // Next-state: burst counting, burst-end detection and regrant without a bubble.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lsv_d   = lsv_q;
    owner_d = owner_q;
    arb_c   = 1'b0;

    case (state_q)
      IDLE: arb_c = 1'b1;
      OWN0: begin
        if (!req0) begin
          arb_c = 1'b1;
        end else if (ack0) begin
          if (last0 || (cnt_q == CNT_END)) arb_c = 1'b1;
          else                             cnt_d = cnt_q + CNT_W'(1);
        end
      end
      OWN1: begin
        if (!req1) begin
          arb_c = 1'b1;
        end else if (ack1) begin
          if (last1 || (cnt_q == CNT_END)) arb_c = 1'b1;
          else                             cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (arb_c) begin
      cnt_d = '0;
      if (pick_valid_c) begin
        state_d = pick_id_c ? OWN1 : OWN0;
        owner_d = pick_id_c;
        lsv_d   = pick_id_c;
      end else begin
        state_d = IDLE;
      end
    end

    busy_d = (state_d != IDLE);
  end

  // State register; producer 0 wins the first arbitration after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lsv_q   <= 1'b1;
      owner_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lsv_q   <= lsv_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Testbench for fifo_write_arbiter: random producers, a fifo occupancy model,
// a transaction-level reference model and a write scoreboard.
module tb_fifo_write_arbiter;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned DEPTH      = 5;
  localparam int unsigned MAX_BURST  = 4;
  localparam int unsigned HIGH_WATER = 24;
  localparam int          OCC_MAX    = 31;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0, last0, ack0, req1, last1, ack1;
  logic [WIDTH-1:0] data0, data1, fifo_write;
  logic [DEPTH-1:0] fifo_occupancy;
  logic             fifo_wen, owner, busy;

  always #5 clk = ~clk;

  fifo_write_arbiter #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST), .HIGH_WATER(HIGH_WATER)
  ) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .data0(data0), .last0(last0), .ack0(ack0),
    .req1(req1), .data1(data1), .last1(last1), .ack1(ack1),
    .fifo_occupancy(fifo_occupancy), .fifo_wen(fifo_wen), .fifo_write(fifo_write),
    .owner(owner), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Fifo occupancy model: counts writes and reads, with a preload hook.
  int   occ = 0;
  logic wen_s = 1'b0, rd_s = 1'b0, rd_en = 1'b0, load_en = 1'b0;
  int   load_val = 0;
  assign fifo_occupancy = occ[DEPTH-1:0];

  always @(posedge clk) begin
    if (load_en) occ <= load_val;
    else         occ <= occ + (wen_s ? 1 : 0) - (rd_s ? 1 : 0);
  end

  // Reference model state: owner id (-1 none), words in burst, last served.
  int   m_own = -1, m_last = 1, m_owner = 0, m_words = 0;
  logic ack0_s = 1'b0, ack1_s = 1'b0;
  logic [WIDTH:0] expq[$];

  function automatic int choose(logic r0, logic r1, int last_served, int o);
    if (o >= int'(HIGH_WATER)) return -1;
`ifdef FIFO_ARB_PRIO_EN
    if (r0) return 0;
    if (r1) return 1;
    return -1;
`else
    if (r0 && r1) return 1 - last_served;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
`endif
  endfunction

  logic       e0, e1, m_arb, m_req, m_lst;
  logic [3:0] exp_v, act_v;

  // Reference model: predicts acks/owner/busy each cycle and queues expected writes.
  always @(negedge clk) begin
    ack0_s = ack0;
    ack1_s = ack1;
    e0 = 1'b0;
    e1 = 1'b0;
    if (reset) begin
      m_own = -1; m_last = 1; m_owner = 0; m_words = 0;
    end else begin
      e0 = (m_own == 0) && req0 && (occ != OCC_MAX);
      e1 = (m_own == 1) && req1 && (occ != OCC_MAX);
    end
    exp_v = {e1, e0, (m_own != -1), (m_owner == 1)};
    act_v = {ack1, ack0, busy, owner};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL ctrl t=%0t ack1,ack0,busy,owner got %b required %b", $time, act_v, exp_v);
    end
    if (e0) expq.push_back({1'b0, data0});
    if (e1) expq.push_back({1'b1, data1});
    if (!reset) begin
      m_arb = 1'b0;
      if (m_own == -1) begin
        m_arb = 1'b1;
      end else begin
        m_req = (m_own == 0) ? req0 : req1;
        m_lst = (m_own == 0) ? last0 : last1;
        if (!m_req) m_arb = 1'b1;
        else if (e0 || e1) begin
          m_words++;
          if (m_lst || m_words == int'(MAX_BURST)) m_arb = 1'b1;
        end
      end
      if (m_arb) begin
        m_words = 0;
        m_own = choose(req0, req1, m_last, occ);
        if (m_own >= 0) begin
          m_last  = m_own;
          m_owner = m_own;
        end
      end
    end
  end

  logic [WIDTH:0] exp_w, got_w;

  // Write monitor: every fifo write must match the oldest predicted write.
  always @(negedge clk) begin
    #1;
    wen_s = fifo_wen;
    rd_s  = rd_en && (occ > 0);
    if (fifo_wen) begin
      checks++;
      got_w = {ack1, fifo_write};
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL write t=%0t unexpected write got %h required none", $time, got_w);
      end else begin
        exp_w = expq.pop_front();
        if (got_w !== exp_w) begin
          errors++;
          $display("FAIL write t=%0t producer,data got %h required %h", $time, got_w, exp_w);
        end
      end
      checks++;
      if (occ >= OCC_MAX) begin
        errors++;
        $display("FAIL overflow t=%0t write with occupancy %0d required below %0d", $time, occ, OCC_MAX);
      end
    end
  end

  // Producer driver state.
  logic             act_p[2];
  int               rem_p[2];
  logic [WIDTH-1:0] dat_p[2];
  int               bursts_left[2];
  int               start_pct[2];
  int               len_min = 1, len_max = 6, abandon_pct = 0, rd_pct = 0;

  task automatic step();
    logic a;
    @(posedge clk);
    #1;
    load_en = 1'b0;
    for (int p = 0; p < 2; p++) begin
      a = (p == 0) ? ack0_s : ack1_s;
      if (act_p[p] && a) begin
        rem_p[p]--;
        dat_p[p] = WIDTH'($urandom);
        if (rem_p[p] == 0) act_p[p] = 1'b0;
      end else if (act_p[p] && int'($urandom_range(99)) < abandon_pct) begin
        act_p[p] = 1'b0;
      end
      if (!act_p[p] && bursts_left[p] > 0 && int'($urandom_range(99)) < start_pct[p]) begin
        act_p[p] = 1'b1;
        rem_p[p] = int'($urandom_range(len_max, len_min));
        dat_p[p] = WIDTH'($urandom);
        bursts_left[p]--;
      end
    end
    req0  = act_p[0];
    data0 = dat_p[0];
    last0 = act_p[0] && (rem_p[0] == 1);
    req1  = act_p[1];
    data1 = dat_p[1];
    last1 = act_p[1] && (rem_p[1] == 1);
    rd_en = int'($urandom_range(99)) < rd_pct;
  endtask

  task automatic stop_all();
    act_p[0] = 1'b0; act_p[1] = 1'b0;
    bursts_left[0] = 0; bursts_left[1] = 0;
    abandon_pct = 0;
  endtask

  task automatic check_occ(string name, int want);
    checks++;
    if (occ != want) begin
      errors++;
      $display("FAIL %s occupancy got %0d required %0d", name, occ, want);
    end
  endtask

  task automatic drain();
    stop_all();
    rd_pct = 100;
    repeat (40) step();
    rd_pct = 0;
  endtask

  initial begin
    int k;
    reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0; last0 = 1'b0; last1 = 1'b0;
    data0 = '0; data1 = '0;
    for (int p = 0; p < 2; p++) begin
      act_p[p] = 1'b0; rem_p[p] = 0; dat_p[p] = '0; bursts_left[p] = 0; start_pct[p] = 0;
    end
    #1 reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    // Single 3-word burst from producer 0 into an empty fifo.
    len_min = 3; len_max = 3; start_pct[0] = 100; bursts_left[0] = 1; rd_pct = 0;
    repeat (8) step();
    check_occ("single_burst", 3);
    drain();

    // Both producers streaming without last: bursts of MAX_BURST alternate.
    len_min = 1000; len_max = 1000;
    start_pct[0] = 100; start_pct[1] = 100; bursts_left[0] = 1; bursts_left[1] = 1;
    rd_pct = 100;
    repeat (30) step();
    drain();

    // Full stall: preload near full while producer 1 is mid-burst.
    start_pct[1] = 100; bursts_left[1] = 1; rd_pct = 0;
    k = 0;
    while (!ack1_s && k < 12) begin step(); k++; end
    checks++;
    if (!ack1_s) begin errors++; $display("FAIL full_grant timeout got no ack1 required ack1"); end
    load_en = 1'b1; load_val = 30;
    repeat (8) step();
    check_occ("full_hold", OCC_MAX);
    rd_pct = 100; step(); rd_pct = 0;
    repeat (6) step();
    check_occ("full_one_more", OCC_MAX);
    drain();

    // High water: no grant at 24, grant once drained to 23.
    step(); load_en = 1'b1; load_val = 24;
    len_min = 2; len_max = 2; start_pct[0] = 100; bursts_left[0] = 1;
    repeat (5) step();
    check_occ("high_water_hold", 24);
    rd_pct = 100; step(); rd_pct = 0;
    repeat (5) step();
    check_occ("high_water_grant", 25);
    drain();

    // Abandon: producer 0 drops its request after two words, producer 1 takes over.
    len_min = 5; len_max = 5; start_pct[0] = 100; bursts_left[0] = 1; rd_pct = 100;
    k = 0;
    while (!ack0_s && k < 12) begin step(); k++; end
    checks++;
    if (!ack0_s) begin errors++; $display("FAIL abandon_grant timeout got no ack0 required ack0"); end
    step();
    act_p[0] = 1'b0; bursts_left[0] = 0;
    len_min = 3; len_max = 3; start_pct[1] = 100; bursts_left[1] = 1;
    repeat (10) step();
    drain();

    // Reset in the middle of a burst.
    len_min = 1000; len_max = 1000;
    start_pct[0] = 100; start_pct[1] = 100; bursts_left[0] = 1; bursts_left[1] = 1;
    rd_pct = 100;
    repeat (7) step();
    checks++;
    if (fifo_wen !== 1'b1) begin errors++; $display("FAIL pre_reset_wen got %b required 1", fifo_wen); end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({ack0, ack1, fifo_wen} !== 3'b000) begin
      errors++;
      $display("FAIL reset_same_cycle ack0,ack1,wen got %b required 000", {ack0, ack1, fifo_wen});
    end
    repeat (2) step();
    reset = 1'b0;
    repeat (12) step();
    drain();

    // Random traffic with varying drain rate and occasional abandons.
    len_min = 1; len_max = 6;
    for (int s = 0; s < 8; s++) begin
      start_pct[0] = 30; start_pct[1] = 30;
      bursts_left[0] = 1000000; bursts_left[1] = 1000000;
      abandon_pct = 3;
      rd_pct = int'($urandom_range(90, 20));
      repeat (250) step();
    end
    drain();

    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty pending got %0d required 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
